// File: rtl/bus_master_arb.sv
// bus_master_arb: two-port round-robin arbiter for the internal register bus.
// It serializes single-word read/write transactions from masters A and B onto
// one address/strobe pair. It then waits for a type-matched ack or a timeout
// and returns a one-cycle done pulse, carrying rdata and err, to the winner.
module bus_master_arb #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 bus_clk,
  input  logic                 bus_reset,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic                 we_a,
  input  logic                 we_b,
  input  logic [ADDRWIDTH-1:0] addr_a,
  input  logic [ADDRWIDTH-1:0] addr_b,
  input  logic [DATAWIDTH-1:0] wdata_a,
  input  logic [DATAWIDTH-1:0] wdata_b,
  output logic                 done_a,
  output logic                 done_b,
  output logic                 err,
  output logic [DATAWIDTH-1:0] rdata,
  output logic [ADDRWIDTH-1:0] bus_addr,
  output logic [DATAWIDTH-1:0] bus_wr_data,
  output logic                 bus_re,
  output logic                 bus_we,
  input  logic [DATAWIDTH-1:0] bus_rd_data,
  input  logic                 bus_rd_ack,
  input  logic                 bus_wr_ack
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t               state_reg, state_next;
  logic                 grant_b_reg, grant_b_next;        // 1 = master B owns the bus
  logic                 last_grant_b_reg, last_grant_b_next;
  logic                 we_reg, we_next;
  logic [7:0]           cnt_reg, cnt_next;
  logic [ADDRWIDTH-1:0] bus_addr_reg, bus_addr_next;
  logic [DATAWIDTH-1:0] bus_wr_data_reg, bus_wr_data_next;
  logic                 bus_re_reg, bus_re_next;
  logic                 bus_we_reg, bus_we_next;
  logic                 done_a_reg, done_a_next;
  logic                 done_b_reg, done_b_next;
  logic                 err_reg, err_next;
  logic [DATAWIDTH-1:0] rdata_reg, rdata_next;
  logic                 pick_b;
  logic                 ack_ok;

  // State and all registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      state_reg        <= ST_IDLE;
      grant_b_reg      <= 1'b0;
      last_grant_b_reg <= 1'b1;   // B counts as last winner, so A wins the first tie
      we_reg           <= 1'b0;
      cnt_reg          <= '0;
      bus_addr_reg     <= '0;
      bus_wr_data_reg  <= '0;
      bus_re_reg       <= 1'b0;
      bus_we_reg       <= 1'b0;
      done_a_reg       <= 1'b0;
      done_b_reg       <= 1'b0;
      err_reg          <= 1'b0;
      rdata_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      grant_b_reg      <= grant_b_next;
      last_grant_b_reg <= last_grant_b_next;
      we_reg           <= we_next;
      cnt_reg          <= cnt_next;
      bus_addr_reg     <= bus_addr_next;
      bus_wr_data_reg  <= bus_wr_data_next;
      bus_re_reg       <= bus_re_next;
      bus_we_reg       <= bus_we_next;
      done_a_reg       <= done_a_next;
      done_b_reg       <= done_b_next;
      err_reg          <= err_next;
      rdata_reg        <= rdata_next;
    end
  end

  // Next-state and next-output logic; strobes and done pulses default low.
  always_comb begin
    state_next        = state_reg;
    grant_b_next      = grant_b_reg;
    last_grant_b_next = last_grant_b_reg;
    we_next           = we_reg;
    cnt_next          = cnt_reg;
    bus_addr_next     = bus_addr_reg;
    bus_wr_data_next  = bus_wr_data_reg;
    bus_re_next       = 1'b0;
    bus_we_next       = 1'b0;
    done_a_next       = 1'b0;
    done_b_next       = 1'b0;
    err_next          = err_reg;
    rdata_next        = rdata_reg;
    // B wins when it is the only requester, or on a tie when A won last time.
    pick_b            = req_b & (~req_a | ~last_grant_b_reg);
    // Only an ack of the same type as the outstanding transaction counts.
    ack_ok            = we_reg ? bus_wr_ack : bus_rd_ack;

    case (state_reg)
      ST_IDLE: begin
        if (req_a || req_b) begin
          grant_b_next     = pick_b;
          we_next          = pick_b ? we_b : we_a;
          bus_addr_next    = pick_b ? addr_b : addr_a;
          bus_wr_data_next = pick_b ? wdata_b : wdata_a;
          // Strobe is registered here so it is visible during ISSUE.
          bus_re_next      = ~(pick_b ? we_b : we_a);
          bus_we_next      = pick_b ? we_b : we_a;
          state_next       = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_next   = '0;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_ok) begin
          rdata_next  = we_reg ? '0 : bus_rd_data;
          err_next    = 1'b0;
          done_a_next = ~grant_b_reg;
          done_b_next = grant_b_reg;
          state_next  = ST_DONE;
        end else if (cnt_reg == TIMEOUT_CNT) begin
          rdata_next  = '0;
          err_next    = 1'b1;
          done_a_next = ~grant_b_reg;
          done_b_next = grant_b_reg;
          state_next  = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_DONE: begin
        last_grant_b_next = grant_b_reg;
        state_next        = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign done_a      = done_a_reg;
  assign done_b      = done_b_reg;
  assign err         = err_reg;
  assign rdata       = rdata_reg;
  assign bus_addr    = bus_addr_reg;
  assign bus_wr_data = bus_wr_data_reg;
  assign bus_re      = bus_re_reg;
  assign bus_we      = bus_we_reg;

endmodule

// File: doc/bus_master_arb.md
# bus_master_arb

Two-port round-robin master arbiter for the internal register bus. It sits between two bus masters and the OR-combined register slaves. Typical masters are the host-interface bridge and the on-chip sequencer. The block serializes their single-word read/write transactions onto one address/strobe pair, waits for the slave's registered ack, and returns read data or a timeout error to the winning master.

## Interface
Parameters:
- ADDRWIDTH, 16: bus address width (byte address; bits [1:0] passed through untouched).
- DATAWIDTH, 32: bus data width.
- TIMEOUT, 255: cycles in WAIT before error; 1..255.

Ports:
- bus_clk  in  1  single clock for all logic.
- bus_reset  in  1  synchronous reset, active-high.
- req_a / req_b  in  1  transaction request, level; held with fields until done.
- we_a / we_b  in  1  1 = write, 0 = read.
- addr_a / addr_b  in  ADDRWIDTH  transaction address.
- wdata_a / wdata_b  in  DATAWIDTH  write data.
- done_a / done_b  out  1  one-cycle completion pulse to the granted master.
- err  out  1  timeout flag; valid only while a done_* is high.
- rdata  out  DATAWIDTH  read result; valid only while a done_* is high.
- bus_addr  out  ADDRWIDTH  registered address to slaves.
- bus_wr_data  out  DATAWIDTH  registered write data.
- bus_re / bus_we  out  1  one-cycle read/write strobes.
- bus_rd_data  in  DATAWIDTH  OR of slave read data (zero when not acking).
- bus_rd_ack / bus_wr_ack  in  1  OR of slave acks.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Encoding is free; all outputs are registered.
- IDLE: if any req is high, choose a grant and latch we/addr/wdata from the winner into bus_addr/bus_wr_data. Go to ISSUE.
  - Grant rule: if only one req is high, that master wins. If both are high, the master not granted last wins.
  - last_grant resets to B, so A wins the first tie.
- ISSUE: exactly one strobe is high for one cycle (bus_re for a read, bus_we for a write). Clear the timeout counter. Go to WAIT.
- WAIT:
  - Accept bus_rd_ack only for reads and bus_wr_ack only for writes; ignore a wrong-type ack.
  - On an accepted ack, capture bus_rd_data into rdata (reads) or load zero (writes). Set err=0 and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT with no accepted ack, set rdata=0, err=1, and go to DONE.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins: no error.
- DONE: pulse done of the granted master for one cycle. Update last_grant and return to IDLE. req inputs are not sampled in DONE.
- Requester rule: drop req in the cycle after done, or keep it high with new fields to issue a new transaction. A master that is still requesting in IDLE starts a fresh arbitration.
- Acks arriving in IDLE, ISSUE or DONE (late acks after a timeout) are ignored. They do not corrupt rdata or err.
- bus_addr and bus_wr_data hold their last value outside ISSUE/WAIT.

## Timing
- Reset values: state=IDLE, bus_re=bus_we=0, done_a=done_b=0, err=0, rdata=0, bus_addr=0, bus_wr_data=0, last_grant=B, counter=0.
- Reset asserted mid-transaction abandons it. No done is issued and strobes drop on the next edge.
- Latency with a registered-ack slave: req high in cycle k → strobe in k+1 → ack in k+2 → done in k+3.
- Minimum spacing between strobes is 4 cycles.
- Timeout case: done with err in cycle k+3+TIMEOUT (no ack ever).
- Throughput: one transaction per 4 cycles minimum. When both masters hold req continuously, grants alternate A, B, A, B.

## Test plan
- Single read: A reads addr 0x0010 and the slave returns 0x12345678 → bus_re high exactly in k+1, bus_addr=0x0010, done_a in k+3 with rdata=0x12345678, err=0, done_b never.
- Single write: B writes 0xCAFEF00D to 0x0024 → bus_we one cycle, bus_wr_data=0xCAFEF00D, done_b in k+3, rdata=0, err=0.
- Contention: req_a and req_b rise in the same cycle and stay high for 4 transactions → grant order A, B, A, B with no cycle lacking a pending grant beyond the 4-cycle spacing.
- Timeout: TIMEOUT=8 and no slave at the address → done_a with err=1, rdata=0 in k+11. A late ack injected in k+12 is ignored and the next transaction is unaffected.
- Boundaries: an ack arriving exactly in the counter==TIMEOUT cycle gives err=0. A wr_ack during a read is ignored and the read times out.
- Reset mid-WAIT: bus_reset pulsed in k+2 → no done pulses and all outputs at reset values. A request after reset is granted to A.
